seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle combinational ALU.
- Same 3-bit opcode map.
- add/sub/logic complete in one cycle; mul/div/mod use an iterative shift-add or restoring datapath instead of combinational `*`, `/` and `%`.
- start/busy/done handshake; registered result and flags.
- Adds a divide-by-zero flag.
- Sits between the register-file read stage and writeback; the controller stalls on busy.

---
 rtl/seq_alu.sv | 193 +++++++++++++++++++
 tb/tb_seq_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake.
// add/sub/and/or/xor finish in one edge; mul uses an iterative shift-add
// datapath and div/mod a restoring divider, each taking WIDTH edges.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             V,
  output logic             C,
  output logic             Z,
  output logic             S,
  output logic             DZ
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MOD = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;     // mul: multiplicand (shifts left); div: original dividend
  logic [WIDTH-1:0] opb;     // mul: multiplier (shifts right); div: divisor
  logic [WIDTH-1:0] acc;     // mul partial product
  logic [WIDTH-1:0] quo;     // div: dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] rem;     // div partial remainder
  logic [CNT_W-1:0] cnt;
  logic             is_mod;
  logic             dz_lat;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;
  logic             is_single;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [CNT_W-1:0] cnt_dec;
  logic             last;
  logic [WIDTH-1:0] long_res;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Single-cycle result, carry/borrow and signed overflow
  always_comb begin
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_c     = 1'b0;
    is_single = 1'b1;
    case (ALUOp)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      default: is_single = 1'b0;
    endcase
  end

  // One iteration of the shift-add multiplier and the restoring divider
  always_comb begin
    acc_nxt  = opb[0] ? (acc + opa) : acc;
    shifted  = {rem, quo[MSB]};
    trial    = shifted - {1'b0, opb};
    fits     = ~trial[WIDTH];
    rem_nxt  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], fits};
    cnt_dec  = cnt - CNT_W'(1);
    last     = (cnt == CNT_W'(1));
    long_res = '0;
    if (state == MUL) begin
      long_res = acc_nxt;
    end else if (dz_lat) begin
      // Divide by zero: fixed results, timing unchanged
      long_res = is_mod ? opa : '1;
    end else begin
      long_res = is_mod ? rem_nxt : quo_nxt;
    end
  end

  // Control FSM, iterative datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      V      <= 1'b0;
      C      <= 1'b0;
      Z      <= 1'b1;
      S      <= 1'b0;
      DZ     <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      is_mod <= 1'b0;
      dz_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_single) begin
              result <= alu_res;
              V      <= alu_v;
              C      <= alu_c;
              Z      <= (alu_res == '0);
              S      <= alu_res[MSB];
              DZ     <= 1'b0;
              done   <= 1'b1;
            end else begin
              opa    <= a;
              opb    <= b;
              acc    <= '0;
              quo    <= a;
              rem    <= '0;
              cnt    <= CNT_W'(WIDTH);
              is_mod <= (ALUOp == OP_MOD);
              dz_lat <= (b == '0);
              busy   <= 1'b1;
              state  <= (ALUOp == OP_MUL) ? MUL : DIV;
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt_dec;
          if (state == MUL) begin
            acc <= acc_nxt;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end
          if (last) begin
            result <= long_res;
            V      <= 1'b0;
            C      <= 1'b0;
            Z      <= (long_res == '0);
            S      <= long_res[MSB];
            DZ     <= (state == DIV) && dz_lat;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32 and WIDTH=8 instances).
module tb_seq_alu;

  logic clk;
  logic rst;

  // WIDTH=32 instance
  logic        s_start;
  logic [31:0] s_a, s_b;
  logic [2:0]  s_op;
  logic        r_busy, r_done, r_v, r_c, r_z, r_s, r_dz;
  logic [31:0] r_result;

  // WIDTH=8 instance
  logic        e_start;
  logic [7:0]  e_a, e_b;
  logic [2:0]  e_op;
  logic        e_busy, e_done, e_v, e_c, e_z, e_s, e_dz;
  logic [7:0]  e_result;

  int tests;
  int fails;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .ALUOp(s_op),
    .busy(r_busy), .done(r_done), .result(r_result),
    .V(r_v), .C(r_c), .Z(r_z), .S(r_s), .DZ(r_dz)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(e_start), .a(e_a), .b(e_b), .ALUOp(e_op),
    .busy(e_busy), .done(e_done), .result(e_result),
    .V(e_v), .C(e_c), .Z(e_z), .S(e_s), .DZ(e_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags32();
    return {r_v, r_c, r_z, r_s, r_dz};
  endfunction

  // Issue a single-cycle op on the 32-bit instance; leaves sampling point after the edge
  task automatic run_short(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    s_op = op; s_a = x; s_b = y; s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  // Issue a mul/div/mod, scramble inputs while busy, stop at the done sample
  task automatic run_long(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_n);
    s_op = op; s_a = x; s_b = y; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    busy_n = r_busy ? 1 : 0;
    lat = 0;
    while (!r_done && lat < 100) begin
      s_a  = $urandom;
      s_b  = $urandom;
      s_op = 3'($urandom);
      tick();
      lat++;
      if (r_busy) busy_n++;
    end
  endtask

  initial begin
    int lat, bn, dones, done_cyc;
    logic [7:0] mul8_res;
    tests = 0; fails = 0;
    rst = 1'b1;
    s_start = 1'b0; s_a = '0; s_b = '0; s_op = '0;
    e_start = 1'b0; e_a = '0; e_b = '0; e_op = '0;
    tick(); tick();

    // Reset state
    check("rst_result", 64'(r_result), 64'h0);
    check("rst_flags", 64'(flags32()), 64'b00100);
    check("rst_busy_done", 64'({r_busy, r_done}), 64'b00);
    rst = 1'b0;
    tick();

    // add/sub flags
    run_short(3'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_res", 64'(r_result), 64'h8000_0000);
    check("add_ovf_flags", 64'(flags32()), 64'b10010);
    check("add_ovf_done", 64'({r_busy, r_done}), 64'b01);
    tick();
    check("add_done_drop", 64'(r_done), 64'h0);
    check("add_hold", 64'(r_result), 64'h8000_0000);
    run_short(3'd0, 32'hFFFF_FFFF, 32'h1);
    check("add_carry_res", 64'(r_result), 64'h0);
    check("add_carry_flags", 64'(flags32()), 64'b01100);
    run_short(3'd1, 32'd3, 32'd5);
    check("sub_borrow_res", 64'(r_result), 64'hFFFF_FFFE);
    check("sub_borrow_flags", 64'(flags32()), 64'b01010);
    run_short(3'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_res", 64'(r_result), 64'h00F0_1200);
    check("and_flags", 64'(flags32()), 64'b00000);
    tick();

    // mul with inputs scrambled while busy
    run_long(3'd2, 32'h0001_0000, 32'h0003_0002, lat, bn);
    check("mul_res", 64'(r_result), 64'h0002_0000);
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_busy_cycles", 64'(bn), 64'd32);
    check("mul_flags", 64'(flags32()), 64'b00000);
    s_a = '0; s_b = '0; s_op = '0;
    tick();
    check("mul_done_pulse", 64'({r_busy, r_done}), 64'b00);
    check("mul_hold", 64'(r_result), 64'h0002_0000);

    // div/mod, including divide by zero
    run_long(3'd3, 32'd100, 32'd7, lat, bn);
    check("div_res", 64'(r_result), 64'd14);
    check("div_latency", 64'(lat), 64'd32);
    check("div_flags", 64'(flags32()), 64'b00000);
    tick();
    run_long(3'd7, 32'd100, 32'd7, lat, bn);
    check("mod_res", 64'(r_result), 64'd2);
    check("mod_latency", 64'(lat), 64'd32);
    tick();
    run_long(3'd3, 32'd9, 32'd0, lat, bn);
    check("div0_res", 64'(r_result), 64'hFFFF_FFFF);
    check("div0_flags", 64'(flags32()), 64'b00011);
    check("div0_latency", 64'(lat), 64'd32);
    tick();
    run_long(3'd7, 32'd9, 32'd0, lat, bn);
    check("mod0_res", 64'(r_result), 64'd9);
    check("mod0_flags", 64'(flags32()), 64'b00001);

    // start in the done cycle of a div is accepted
    tick();
    run_long(3'd3, 32'd50, 32'd5, lat, bn);
    check("ovl_div_res", 64'(r_result), 64'd10);
    check("ovl_div_done", 64'(r_done), 64'h1);
    run_short(3'd0, 32'd1, 32'd1);
    check("ovl_add_res", 64'(r_result), 64'd2);
    check("ovl_add_done", 64'({r_busy, r_done}), 64'b01);
    tick();
    check("ovl_done_drop", 64'(r_done), 64'h0);

    // reset in the middle of a mul
    s_op = 3'd2; s_a = 32'd3; s_b = 32'd5; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (5) tick();
    check("midmul_busy", 64'(r_busy), 64'h1);
    rst = 1'b1;
    #1;
    check("midmul_rst_res", 64'(r_result), 64'h0);
    check("midmul_rst_flags", 64'(flags32()), 64'b00100);
    check("midmul_rst_busy", 64'({r_busy, r_done}), 64'b00);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (r_done || r_busy) dones++;
    end
    check("midmul_no_done", 64'(dones), 64'd0);
    run_short(3'd0, 32'd5, 32'd3);
    check("post_rst_add", 64'(r_result), 64'd8);
    check("post_rst_add_hs", 64'({r_busy, r_done}), 64'b01);
    tick();
    check("post_rst_done_drop", 64'(r_done), 64'h0);

    // WIDTH=8 back-to-back xor then mul, with ignored starts while busy
    dones = 0; done_cyc = -1; mul8_res = '0;
    e_op = 3'd6; e_a = 8'hF0; e_b = 8'hFF; e_start = 1'b1;
    tick();
    check("w8_xor_res", 64'(e_result), 64'h0F);
    check("w8_xor_done", 64'({e_busy, e_done}), 64'b01);
    if (e_done) dones++;
    e_op = 3'd2; e_a = 8'h0F; e_b = 8'h11;
    tick();
    e_start = 1'b0;
    check("w8_mul_busy", 64'({e_busy, e_done}), 64'b10);
    for (int i = 1; i <= 20; i++) begin
      if (i == 2 || i == 4) begin
        e_op = 3'd0; e_a = 8'h01; e_b = 8'h01; e_start = 1'b1;
      end else begin
        e_start = 1'b0;
      end
      tick();
      if (e_done) begin
        dones++;
        done_cyc = i;
        mul8_res = e_result;
      end
    end
    check("w8_mul_res", 64'(mul8_res), 64'hFF);
    check("w8_mul_latency", 64'(done_cyc), 64'd8);
    check("w8_done_count", 64'(dones), 64'd2);
    check("w8_mul_flags", 64'({e_v, e_c, e_z, e_s, e_dz}), 64'b00010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
